nn_out_axis_serializer: RTL and testbench
=========================================

Name: nn_out_axis_serializer

Overview:
- Downstream of the network top. It consumes the full-width output vector of the last layer, presented as a one-cycle valid pulse with all neuron values packed.
- It serializes the vector onto an AXI-Stream master, one neuron per beat, with backpressure and TLAST framing. This replaces the free-running shift register that has no backpressure.
- A second holding buffer absorbs one vector that arrives while a transfer is in flight. Further vectors are dropped and counted.

Parameters:
- NUM_NEURONS, 10: neurons per output vector (beats per frame).
- DATA_WIDTH, 16: bits per neuron value, two's complement.
- CNT_WIDTH, 16: width of the dropped-vector counter.

Ports:
- s_axi_aclk, in, 1: clock.
- s_axi_aresetn, in, 1: reset, asynchronous, active-low.
- in_valid, in, 1: one-cycle pulse; in_data is valid this cycle.
- in_data, in, NUM_NEURONS*DATA_WIDTH: packed vector; neuron k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tdata, out, DATA_WIDTH: current beat.
- m_axis_tvalid, out, 1: beat valid.
- m_axis_tready, in, 1: sink ready.
- m_axis_tlast, out, 1: final beat of the frame.
- busy, out, 1: active or pending buffer occupied.
- overflow, out, 1: sticky; set when a vector was dropped.
- drop_count, out, CNT_WIDTH: saturating count of dropped vectors.
- clear_overflow, in, 1: synchronous clear of overflow and drop_count.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by use):
  - m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, overflow, drop_count = 0.
  - Both buffers empty; beat index = 0; FSM = IDLE.
- Storage:
  - Active buffer: NUM_NEURONS*DATA_WIDTH, plus beat index 0..NUM_NEURONS-1.
  - Pending buffer: NUM_NEURONS*DATA_WIDTH, plus pend_full flag.
- FSM states: IDLE, SEND.
- IDLE + in_valid:
  - Load in_data into active; index = 0; go to SEND.
  - Latency: in_valid at cycle N gives m_axis_tvalid=1 at cycle N+1, with tdata = neuron 0.
- SEND:
  - tvalid=1; tdata = active neuron[index]; tlast = (index == NUM_NEURONS-1).
  - tdata and tlast hold stable while tvalid & ~tready.
  - Handshake (tvalid & tready), not last beat: index+1.
  - Handshake on last beat, pend_full=1: move pending to active, clear pend_full, index = 0, stay in SEND. No bubble cycle: tvalid stays 1 and the next cycle shows the new neuron 0.
  - Handshake on last beat, pend_full=0, no in_valid: go to IDLE; tvalid=0 next cycle.
- in_valid during SEND:
  - pend_full=0: capture into pending; set pend_full.
  - pend_full=1 and no last-beat handshake this cycle: drop the new vector; overflow=1; drop_count+1, saturating at all-ones.
- Simultaneous last-beat handshake and in_valid:
  - pend_full=0: new vector loads directly into active; stay in SEND.
  - pend_full=1: pending moves to active, new vector goes to pending. No drop.
- busy = (state==SEND) | pend_full.
- clear_overflow: zeroes overflow and drop_count. If a drop occurs in the same cycle, the result is drop_count=1, overflow=1.
- Values pass through unmodified; no arithmetic on data.

Optional Feature:
- Macro: NN_OUT_ARGMAX_EN.
- Defined:
  - Each frame carries NUM_NEURONS+1 beats.
  - The extra final beat holds the index of the maximum signed neuron value, zero-extended to DATA_WIDTH; on a tie, the lowest index wins.
  - The index is computed when a vector is loaded into a buffer and stored alongside it. It must not be recomputed on the shifted data.
  - tlast asserts only on the index beat; the index beat counts as the last beat for all pending/IDLE rules above.
- Not defined: NUM_NEURONS beats per frame; tlast on neuron NUM_NEURONS-1; no argmax logic is synthesized.

Test Plan (NUM_NEURONS=4, DATA_WIDTH=16):
- Basic frame: reset; tready=1; one in_valid pulse with neurons {0x0001, 0x0002, 0x0003, 0x0004} -> tvalid from cycle N+1 for 4 consecutive beats 0x0001..0x0004; tlast on beat 4 only; then tvalid=0, busy=0.
- Backpressure: same vector; tready toggles 1,0,0,1,... -> tdata/tlast held while stalled; exactly 4 beats in order; no duplicates.
- Pending, no bubble: tready=1; vector A {0xA0..0xA3}, then vector B two cycles later -> 8 back-to-back beats A0..A3, B0..B3 with no tvalid gap; tlast on A3 and B3; overflow=0.
- Overflow and clear: tready=0; three in_valid pulses A, B, C -> C dropped, overflow=1, drop_count=1; release tready -> frames A then B only. Then pulse clear_overflow -> overflow=0, drop_count=0.
- Simultaneous events and reset: with pend_full=1, assert in_valid in the same cycle as the last-beat handshake -> no drop; next frames are pending then new. Separately, deassert s_axi_aresetn mid-frame -> tvalid=0, busy=0 immediately, with no dependence on the clock.
- With NN_OUT_ARGMAX_EN: vector {0xFFFF(-1), 0x0007, 0x0007, 0x8000} -> 5 beats; fifth beat = 0x0001; tlast only on beat 5.

Source files
------------

// File: rtl/nn_out_axis_serializer.sv
// Serializes a packed output vector onto an AXI-Stream master, one neuron per beat,
// with a one-deep pending buffer. Optional argmax trailer beat: define NN_OUT_ARGMAX_EN.
module nn_out_axis_serializer #(
    parameter int NUM_NEURONS = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              s_axi_aclk,
    input  logic                              s_axi_aresetn,
    input  logic                              in_valid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic                              busy,
    output logic                              overflow,
    output logic [CNT_WIDTH-1:0]              drop_count,
    input  logic                              clear_overflow
);

    localparam int unsigned VEC_W = NUM_NEURONS * DATA_WIDTH;
`ifdef NN_OUT_ARGMAX_EN
    localparam int unsigned FRAME_BEATS = NUM_NEURONS + 1;
`else
    localparam int unsigned FRAME_BEATS = NUM_NEURONS;
`endif
    localparam int unsigned LAST_IDX = FRAME_BEATS - 1;
    localparam int IDX_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [VEC_W-1:0]     act_buf, pend_buf;
    logic [DATA_WIDTH-1:0] act_amax, pend_amax, in_amax;
    logic                 pend_full;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic                 hs, last_hs, drop;

    // Beats past the last neuron carry the stored argmax index.
    function automatic logic [DATA_WIDTH-1:0] beat_of(input logic [VEC_W-1:0] vec,
                                                      input logic [DATA_WIDTH-1:0] amax,
                                                      input int unsigned i);
        if (i >= NUM_NEURONS) return amax;
        return vec[i*DATA_WIDTH +: DATA_WIDTH];
    endfunction

`ifdef NN_OUT_ARGMAX_EN
    // Strict greater-than keeps the lowest index on ties.
    function automatic logic [DATA_WIDTH-1:0] argmax_of(input logic [VEC_W-1:0] vec);
        logic signed [DATA_WIDTH-1:0] best;
        int unsigned best_i;
        best   = vec[DATA_WIDTH-1:0];
        best_i = 0;
        for (int unsigned k = 1; k < NUM_NEURONS; k++) begin
            if ($signed(vec[k*DATA_WIDTH +: DATA_WIDTH]) > best) begin
                best   = vec[k*DATA_WIDTH +: DATA_WIDTH];
                best_i = k;
            end
        end
        return DATA_WIDTH'(best_i);
    endfunction

    assign in_amax = argmax_of(in_data);
`else
    assign in_amax = '0;
`endif

    assign hs      = m_axis_tvalid & m_axis_tready;
    assign last_hs = hs & m_axis_tlast;
    assign drop    = (state == SEND) & in_valid & pend_full & ~last_hs;
    assign idx_nxt = idx + 1'b1;
    assign busy    = (state == SEND) | pend_full;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state         <= IDLE;
            act_buf       <= '0;
            pend_buf      <= '0;
            act_amax      <= '0;
            pend_amax     <= '0;
            pend_full     <= 1'b0;
            idx           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            overflow      <= 1'b0;
            drop_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        act_buf       <= in_data;
                        act_amax      <= in_amax;
                        idx           <= '0;
                        state         <= SEND;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= beat_of(in_data, in_amax, 0);
                        m_axis_tlast  <= (LAST_IDX == 0);
                    end
                end
                SEND: begin
                    if (last_hs) begin
                        idx          <= '0;
                        m_axis_tlast <= (LAST_IDX == 0);
                        if (pend_full) begin
                            // Pending promotes with no bubble; a coincident vector refills pending.
                            act_buf      <= pend_buf;
                            act_amax     <= pend_amax;
                            m_axis_tdata <= beat_of(pend_buf, pend_amax, 0);
                            if (in_valid) begin
                                pend_buf  <= in_data;
                                pend_amax <= in_amax;
                            end else begin
                                pend_full <= 1'b0;
                            end
                        end else if (in_valid) begin
                            act_buf      <= in_data;
                            act_amax     <= in_amax;
                            m_axis_tdata <= beat_of(in_data, in_amax, 0);
                        end else begin
                            state         <= IDLE;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tdata  <= '0;
                        end
                    end else begin
                        if (hs) begin
                            idx          <= idx_nxt;
                            m_axis_tdata <= beat_of(act_buf, act_amax, 32'(idx_nxt));
                            m_axis_tlast <= (idx_nxt == IDX_W'(LAST_IDX));
                        end
                        if (in_valid && !pend_full) begin
                            pend_buf  <= in_data;
                            pend_amax <= in_amax;
                            pend_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (drop) begin
                overflow <= 1'b1;
                if (clear_overflow)   drop_count <= CNT_WIDTH'(1);
                else if (!(&drop_count)) drop_count <= drop_count + 1'b1;
            end else if (clear_overflow) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_nn_out_axis_serializer.sv
// Directed bench for nn_out_axis_serializer (NUM_NEURONS=4) with a beat scoreboard.
module tb_nn_out_axis_serializer;

    localparam int NN = 4;
    localparam int DW = 16;
    localparam int CW = 16;
`ifdef NN_OUT_ARGMAX_EN
    localparam int FB = NN + 1;
`else
    localparam int FB = NN;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [NN*DW-1:0]  in_data = '0;
    logic [DW-1:0]     tdata;
    logic              tvalid;
    logic              tready = 1'b0;
    logic              tlast;
    logic              busy;
    logic              overflow;
    logic [CW-1:0]     drop_count;
    logic              clear_overflow = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [DW:0] exp_q[$];

    logic          held_pending = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last;

    always #5 clk = ~clk;

    nn_out_axis_serializer #(.NUM_NEURONS(NN), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .s_axi_aclk     (clk),
        .s_axi_aresetn  (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .m_axis_tdata   (tdata),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tlast   (tlast),
        .busy           (busy),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference argmax: scan downward, >= so the lowest index wins ties.
    function automatic logic [DW-1:0] ref_argmax(input logic [NN*DW-1:0] v);
        int bi = NN - 1;
        logic signed [DW-1:0] bv = v[(NN-1)*DW +: DW];
        for (int k = NN - 2; k >= 0; k--) begin
            if ($signed(v[k*DW +: DW]) >= bv) begin
                bv = v[k*DW +: DW];
                bi = k;
            end
        end
        return DW'(bi);
    endfunction

    task automatic push_frame(input logic [NN*DW-1:0] v);
        for (int k = 0; k < NN; k++)
            exp_q.push_back({(k == FB - 1), v[k*DW +: DW]});
`ifdef NN_OUT_ARGMAX_EN
        exp_q.push_back({1'b1, ref_argmax(v)});
`endif
    endtask

    task automatic pulse(input logic [NN*DW-1:0] v, input bit expect_out);
        in_valid = 1'b1;
        in_data  = v;
        if (expect_out) push_frame(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit use_pat);
        logic [3:0] pat = 4'b1001;
        bit done = 0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (exp_q.size() == 0 && !tvalid && !busy) done = 1;
            else begin
                tready = use_pat ? pat[cyc % 4] : 1'b1;
                step();
            end
        end
        tready = 1'b1;
        check("drain_done", 32'(done), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic last_beat_collision(input logic [NN*DW-1:0] a, input logic [NN*DW-1:0] b,
                                       input bit with_pending, input logic [NN*DW-1:0] c);
        bit seen = 0;
        tready = 1'b0;
        pulse(a, 1);
        if (with_pending) pulse(b, 1);
        tready = 1'b1;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            if (tvalid && tlast) seen = 1;
            else step();
        end
        check("saw_last_beat", 32'(seen), 32'd1);
        pulse(c, 1);
        drain(0);
        check("collision_overflow", 32'(overflow), 32'd0);
        check("collision_drops", 32'(drop_count), 32'd0);
    endtask

    // Scoreboard monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (!rst_n) begin
            held_pending <= 1'b0;
        end else begin
            if (tvalid && held_pending) begin
                check("stall_data", 32'(tdata), 32'(held_data));
                check("stall_last", 32'(tlast), 32'(held_last));
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) check("extra_beat", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(tdata), 32'(e[DW-1:0]));
                    check("beat_last", 32'(tlast), 32'(e[DW]));
                end
            end
            held_pending <= tvalid & ~tready;
            held_data    <= tdata;
            held_last    <= tlast;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NN*DW-1:0] va, vb, vc, vd, ve;
        int gaps;
        va = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        vb = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        vc = {16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
        vd = {16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0};
        ve = {16'h7FFF, 16'h8001, 16'h1234, 16'hFFFE};

        // Reset state
        step(); step();
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic frame, one-cycle latency
        tready = 1'b1;
        pulse(va, 1);
        check("lat_tvalid", 32'(tvalid), 32'd1);
        check("lat_tdata", 32'(tdata), 32'h0001);
        drain(0);
        check("basic_busy", 32'(busy), 32'd0);
        check("basic_tvalid", 32'(tvalid), 32'd0);

        // Backpressure 1,0,0,1,...
        tready = 1'b0;
        pulse(va, 1);
        drain(1);

        // Pending with no bubble
        tready = 1'b1;
        pulse(vb, 1);
        gaps = 0;
        for (int i = 0; i < 2 * FB; i++) begin
            if (!tvalid) gaps++;
            if (i == 1) begin
                in_valid = 1'b1;
                in_data  = vc;
                push_frame(vc);
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
        check("no_bubble_gaps", 32'(gaps), 32'd0);
        drain(0);
        check("pend_overflow", 32'(overflow), 32'd0);

        // Overflow then clear
        tready = 1'b0;
        pulse(vb, 1);
        pulse(vc, 1);
        pulse(vd, 0);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(drop_count), 32'd1);
        check("ovf_busy", 32'(busy), 32'd1);
        pulse(vd, 0);
        check("ovf_count2", 32'(drop_count), 32'd2);
        drain(0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("clr_flag", 32'(overflow), 32'd0);
        check("clr_count", 32'(drop_count), 32'd0);

        // Clear coinciding with a drop
        tready = 1'b0;
        pulse(vb, 1);
        pulse(vc, 1);
        pulse(vd, 0);
        pulse(vd, 0);
        check("pre_clr_count", 32'(drop_count), 32'd2);
        clear_overflow = 1'b1;
        pulse(vd, 0);
        clear_overflow = 1'b0;
        check("clr_drop_count", 32'(drop_count), 32'd1);
        check("clr_drop_flag", 32'(overflow), 32'd1);
        drain(0);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;

        // In_valid on the last-beat handshake, with and without pending
        last_beat_collision(vb, vc, 1, vd);
        last_beat_collision(vc, vb, 0, ve);

`ifdef NN_OUT_ARGMAX_EN
        // Argmax trailer with a tie and a negative extreme
        tready = 1'b1;
        pulse({16'h8000, 16'h0007, 16'h0007, 16'hFFFF}, 1);
        check("amax_model", 32'(ref_argmax({16'h8000, 16'h0007, 16'h0007, 16'hFFFF})), 32'd1);
        drain(0);
`endif

        // Asynchronous reset mid-frame
        tready = 1'b1;
        pulse(va, 1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", 32'(tvalid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_tvalid", 32'(tvalid), 32'd0);
        check("post_rst_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
